// File: rtl/mult_seq_pkg.sv
// Shared constants and types for the multiply/popcount bus-master sequencer.
package mult_seq_pkg;

    localparam logic [15:0] ADDR_A1   = 16'h0380;
    localparam logic [15:0] ADDR_A2   = 16'h0388;
    localparam logic [15:0] ADDR_W    = 16'h0390;
    localparam logic [15:0] ADDR_L    = 16'h0398;
    localparam logic [15:0] ADDR_CTRL = 16'h03A0;

    localparam int STAT_DONE_BIT  = 1;
    localparam int STAT_VALID_BIT = 0;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WR_A1,
        ST_WR_A2,
        ST_WR_GO,
        ST_RD_STAT,
        ST_RD_W,
        ST_RD_L,
        ST_RESP
    } state_t;

    typedef enum logic [1:0] {
        PH_SETUP,
        PH_STROBE,
        PH_HOLD
    } phase_t;

    function automatic logic is_write(input state_t s);
        return (s == ST_WR_A1) || (s == ST_WR_A2) || (s == ST_WR_GO);
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO with registered flags and a registered show-ahead head word.
module sync_fifo #(
    parameter int WIDTH = 48,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             pop,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [WIDTH-1:0] rd_data_reg;
    logic [AW-1:0]    wr_ptr_reg, rd_ptr_reg, rd_ptr_next;
    logic [AW:0]      count_reg, count_next;
    logic             full_reg, empty_reg;
    logic             push_ok, pop_ok;

    assign push_ok = push && !full_reg;
    assign pop_ok  = pop && !empty_reg;

    always_comb begin
        rd_ptr_next = rd_ptr_reg;
        if (pop_ok)
            rd_ptr_next = rd_ptr_reg + 1'b1;
        count_next = count_reg;
        case ({push_ok, pop_ok})
            2'b10:   count_next = count_reg + 1'b1;
            2'b01:   count_next = count_reg - 1'b1;
            default: count_next = count_reg;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
            full_reg   <= 1'b0;
            empty_reg  <= 1'b1;
        end else begin
            if (push_ok)
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            rd_ptr_reg <= rd_ptr_next;
            count_reg  <= count_next;
            full_reg   <= (count_next == (AW+1)'(DEPTH));
            empty_reg  <= (count_next == '0);
        end
    end

    // Head register tracks the next head slot; a write into that slot bypasses the array.
    always_ff @(posedge clk) begin
        if (push_ok)
            mem[wr_ptr_reg] <= wr_data;
        rd_data_reg <= (push_ok && (wr_ptr_reg == rd_ptr_next)) ? wr_data : mem[rd_ptr_next];
    end

    assign rd_data = rd_data_reg;
    assign full    = full_reg;
    assign empty   = empty_reg;

endmodule

// File: rtl/mult_seq_master.sv
// Sequences buffered operand pairs through the multiply/popcount peripheral's
// register protocol and returns one result per command.
module mult_seq_master
    import mult_seq_pkg::*;
#(
    parameter int CMD_DEPTH  = 4,
    parameter int STROBE_LEN = 2,
    parameter int POLL_LIMIT = 64
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [23:0] cmd_a1,
    input  logic [23:0] cmd_a2,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_w,
    output logic [5:0]  rsp_l,
    output logic        rsp_ovf,
    output logic        rsp_timeout,
    output logic [15:0] saddress,
    output logic        swr,
    output logic        srd,
    output logic [31:0] sdata_wr,
    input  logic [31:0] sdata_rd,
    output logic        busy,
    output logic [15:0] op_count
);
    localparam int CW = (STROBE_LEN > 1) ? $clog2(STROBE_LEN) : 1;
    localparam int PW = $clog2(POLL_LIMIT + 1);

    logic        fifo_full, fifo_empty, fifo_pop;
    logic [47:0] head;

    state_t        state_reg;
    phase_t        phase_reg;
    logic [CW-1:0] strobe_cnt_reg;
    logic [PW-1:0] poll_cnt_reg;
    logic [23:0]   a2_reg;
    logic [15:0]   saddress_reg, op_count_reg;
    logic [31:0]   sdata_wr_reg, rsp_w_reg;
    logic [5:0]    rsp_l_reg;
    logic          swr_reg, srd_reg, busy_reg;
    logic          rsp_valid_reg, rsp_ovf_reg, rsp_timeout_reg;

    sync_fifo #(.WIDTH(48), .DEPTH(CMD_DEPTH)) u_cmd_fifo (
        .clk     (clk),
        .reset   (reset),
        .push    (cmd_valid),
        .wr_data ({cmd_a1, cmd_a2}),
        .pop     (fifo_pop),
        .rd_data (head),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    assign fifo_pop = (state_reg == ST_IDLE) && !fifo_empty && !rsp_valid_reg;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg       <= ST_IDLE;
            phase_reg       <= PH_SETUP;
            strobe_cnt_reg  <= '0;
            poll_cnt_reg    <= '0;
            a2_reg          <= '0;
            saddress_reg    <= '0;
            sdata_wr_reg    <= '0;
            swr_reg         <= 1'b0;
            srd_reg         <= 1'b0;
            busy_reg        <= 1'b0;
            op_count_reg    <= '0;
            rsp_valid_reg   <= 1'b0;
            rsp_w_reg       <= '0;
            rsp_l_reg       <= '0;
            rsp_ovf_reg     <= 1'b0;
            rsp_timeout_reg <= 1'b0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (fifo_pop) begin
                        state_reg       <= ST_WR_A1;
                        phase_reg       <= PH_SETUP;
                        busy_reg        <= 1'b1;
                        saddress_reg    <= ADDR_A1;
                        sdata_wr_reg    <= {8'h0, head[47:24]};
                        a2_reg          <= head[23:0];
                        rsp_w_reg       <= '0;
                        rsp_l_reg       <= '0;
                        rsp_ovf_reg     <= 1'b0;
                        rsp_timeout_reg <= 1'b0;
                    end
                end
                ST_RESP: begin
                    if (rsp_ready) begin
                        rsp_valid_reg <= 1'b0;
                        op_count_reg  <= op_count_reg + 16'd1;
                        busy_reg      <= 1'b0;
                        state_reg     <= ST_IDLE;
                    end
                end
                default: begin
                    case (phase_reg)
                        PH_SETUP: begin
                            phase_reg      <= PH_STROBE;
                            strobe_cnt_reg <= '0;
                            if (is_write(state_reg))
                                swr_reg <= 1'b1;
                            else
                                srd_reg <= 1'b1;
                        end
                        PH_STROBE: begin
                            if (strobe_cnt_reg == CW'(STROBE_LEN - 1)) begin
                                swr_reg   <= 1'b0;
                                srd_reg   <= 1'b0;
                                phase_reg <= PH_HOLD;
                            end else begin
                                strobe_cnt_reg <= strobe_cnt_reg + 1'b1;
                            end
                        end
                        PH_HOLD: begin
                            // End of access: sample read data and program the next access.
                            phase_reg <= PH_SETUP;
                            case (state_reg)
                                ST_WR_A1: begin
                                    state_reg    <= ST_WR_A2;
                                    saddress_reg <= ADDR_A2;
                                    sdata_wr_reg <= {8'h0, a2_reg};
                                end
                                ST_WR_A2: begin
                                    state_reg    <= ST_WR_GO;
                                    saddress_reg <= ADDR_CTRL;
                                    sdata_wr_reg <= '0;
                                end
                                ST_WR_GO: begin
                                    state_reg    <= ST_RD_STAT;
                                    poll_cnt_reg <= '0;
                                end
                                ST_RD_STAT: begin
                                    rsp_ovf_reg  <= !sdata_rd[STAT_VALID_BIT];
                                    poll_cnt_reg <= poll_cnt_reg + 1'b1;
                                    if (sdata_rd[STAT_DONE_BIT]) begin
                                        state_reg    <= ST_RD_W;
                                        saddress_reg <= ADDR_W;
                                    end else if (poll_cnt_reg == PW'(POLL_LIMIT - 1)) begin
                                        state_reg       <= ST_RESP;
                                        rsp_valid_reg   <= 1'b1;
                                        rsp_timeout_reg <= 1'b1;
                                        rsp_ovf_reg     <= 1'b0;
                                    end
                                end
                                ST_RD_W: begin
                                    rsp_w_reg    <= sdata_rd;
                                    state_reg    <= ST_RD_L;
                                    saddress_reg <= ADDR_L;
                                end
                                ST_RD_L: begin
                                    rsp_l_reg     <= sdata_rd[5:0];
                                    state_reg     <= ST_RESP;
                                    rsp_valid_reg <= 1'b1;
                                end
                                default: state_reg <= ST_IDLE;
                            endcase
                        end
                        default: phase_reg <= PH_SETUP;
                    endcase
                end
            endcase
        end
    end

    assign cmd_ready   = !fifo_full;
    assign rsp_valid   = rsp_valid_reg;
    assign rsp_w       = rsp_w_reg;
    assign rsp_l       = rsp_l_reg;
    assign rsp_ovf     = rsp_ovf_reg;
    assign rsp_timeout = rsp_timeout_reg;
    assign saddress    = saddress_reg;
    assign swr         = swr_reg;
    assign srd         = srd_reg;
    assign sdata_wr    = sdata_wr_reg;
    assign busy        = busy_reg;
    assign op_count    = op_count_reg;

endmodule

// File: tb/tb_mult_seq_master.sv
// Directed bench for mult_seq_master with a behavioural multiply/popcount peripheral.
module tb_mult_seq_master;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        cmd_valid = 1'b0;
    logic [23:0] cmd_a1 = '0;
    logic [23:0] cmd_a2 = '0;
    logic        rsp_ready = 1'b0;
    logic        cmd_ready, rsp_valid, rsp_ovf, rsp_timeout, swr, srd, busy;
    logic [31:0] rsp_w, sdata_wr, sdata_rd;
    logic [5:0]  rsp_l;
    logic [15:0] saddress, op_count;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    mult_seq_master dut (
        .clk         (clk),
        .reset       (reset),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_a1      (cmd_a1),
        .cmd_a2      (cmd_a2),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp_w       (rsp_w),
        .rsp_l       (rsp_l),
        .rsp_ovf     (rsp_ovf),
        .rsp_timeout (rsp_timeout),
        .saddress    (saddress),
        .swr         (swr),
        .srd         (srd),
        .sdata_wr    (sdata_wr),
        .sdata_rd    (sdata_rd),
        .busy        (busy),
        .op_count    (op_count)
    );

    // Peripheral model: status reports done once done_after status reads have occurred.
    logic [23:0] m_a1 = '0;
    logic [23:0] m_a2 = '0;
    logic [47:0] m_prod;
    logic        swr_q = 1'b0;
    logic        srd_q = 1'b0;
    int          stat_reads = 0;
    int          done_after = 1;
    logic [15:0] addr_log [$];

    assign m_prod = {24'h0, m_a1} * {24'h0, m_a2};

    always @(posedge clk) begin
        swr_q <= swr;
        srd_q <= srd;
        if (reset) begin
            stat_reads <= 0;
        end else begin
            if (swr && !swr_q) begin
                addr_log.push_back(saddress);
                case (saddress)
                    16'h0380: m_a1 <= sdata_wr[23:0];
                    16'h0388: m_a2 <= sdata_wr[23:0];
                    16'h03A0: stat_reads <= 0;
                    default: ;
                endcase
            end
            if (srd && !srd_q) begin
                addr_log.push_back(saddress);
                if (saddress == 16'h03A0)
                    stat_reads <= stat_reads + 1;
            end
        end
    end

    always_comb begin
        sdata_rd = 32'h0;
        case (saddress)
            16'h0390: sdata_rd = m_prod[31:0];
            16'h0398: sdata_rd = 32'($countones(m_prod[31:0]));
            16'h03A0: sdata_rd = {30'h0, (stat_reads >= done_after), (m_prod[47:32] == 16'h0)};
            default:  sdata_rd = 32'h0;
        endcase
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic send_cmd(input logic [23:0] a1, input logic [23:0] a2);
        int n = 0;
        @(negedge clk);
        while (!cmd_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!cmd_ready)
            check("cmd_ready_wait", 0, 1);
        cmd_a1 = a1;
        cmd_a2 = a2;
        cmd_valid = 1'b1;
        @(posedge clk);
        #1 cmd_valid = 1'b0;
        $display("cmd  a1=%06h a2=%06h", a1, a2);
    endtask

    task automatic get_rsp(output logic [31:0] w, output logic [5:0] l,
                           output logic ovf, output logic tmo);
        int n = 0;
        @(negedge clk);
        while (!rsp_valid && n < 2000) begin
            @(negedge clk);
            n++;
        end
        if (!rsp_valid)
            check("rsp_valid_wait", 0, 1);
        w = rsp_w;
        l = rsp_l;
        ovf = rsp_ovf;
        tmo = rsp_timeout;
        rsp_ready = 1'b1;
        @(posedge clk);
        #1 rsp_ready = 1'b0;
        $display("rsp  w=%08h l=%0d ovf=%b timeout=%b", w, l, ovf, tmo);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    logic [31:0] r_w;
    logic [5:0]  r_l;
    logic        r_ovf, r_to;
    logic        busy1, found;
    int          lat;
    logic [15:0] exp_addr [7] = '{16'h0380, 16'h0388, 16'h03A0, 16'h03A0, 16'h03A0, 16'h0390, 16'h0398};
    logic [31:0] exp_w [5] = '{32'd1, 32'd4, 32'd9, 32'd16, 32'd25};
    logic [5:0]  exp_l [5] = '{6'd1, 6'd1, 6'd2, 6'd1, 6'd3};

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        // Reset state
        repeat (3) @(negedge clk);
        check("rst_cmd_ready", cmd_ready, 1);
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_op_count", op_count, 0);
        check("rst_swr", swr, 0);
        check("rst_srd", srd, 0);
        check("rst_saddress", saddress, 0);
        reset = 1'b0;

        // Latency with one status read: rsp_valid rises 25 edges after the push
        done_after = 1;
        send_cmd(24'd2, 24'd3);
        check("busy_before_pop", busy, 0);
        lat = 0;
        busy1 = 1'b0;
        for (int n = 1; n <= 200; n++) begin
            @(posedge clk);
            #1;
            if (n == 1)
                busy1 = busy;
            if (rsp_valid) begin
                lat = n;
                break;
            end
        end
        check("busy_after_pop", busy1, 1);
        check("rsp_latency", lat, 25);
        get_rsp(r_w, r_l, r_ovf, r_to);
        check("t1_w", r_w, 32'd6);
        check("t1_l", r_l, 6'd2);
        check("t1_ovf", r_ovf, 0);
        check("t1_timeout", r_to, 0);
        check("busy_after_hs", busy, 0);
        check("t1_op_count", op_count, 1);

        // 3 x 5 with done on the second poll, plus address sequence
        done_after = 2;
        addr_log.delete();
        send_cmd(24'd3, 24'd5);
        get_rsp(r_w, r_l, r_ovf, r_to);
        check("t2_w", r_w, 32'd15);
        check("t2_l", r_l, 6'd4);
        check("t2_ovf", r_ovf, 0);
        check("t2_timeout", r_to, 0);
        check("t2_addr_count", addr_log.size(), 7);
        for (int i = 0; i < 7; i++)
            check($sformatf("t2_addr%0d", i), (i < addr_log.size()) ? addr_log[i] : 16'hFFFF, exp_addr[i]);

        // Overflowing product
        done_after = 1;
        send_cmd(24'hFFFFFF, 24'hFFFFFF);
        get_rsp(r_w, r_l, r_ovf, r_to);
        check("t3_w", r_w, 32'hFE000001);
        check("t3_l", r_l, 6'd8);
        check("t3_ovf", r_ovf, 1);
        check("t3_timeout", r_to, 0);

        // Never done: timeout after exactly 64 polls, outputs forced to zero
        done_after = 100000;
        send_cmd(24'hFFFFFF, 24'h001000);
        get_rsp(r_w, r_l, r_ovf, r_to);
        check("t4_poll_reads", stat_reads, 64);
        check("t4_w", r_w, 0);
        check("t4_l", r_l, 0);
        check("t4_ovf", r_ovf, 0);
        check("t4_timeout", r_to, 1);

        // Backpressure: five accepted, sixth refused while responses are held
        do_reset();
        done_after = 1;
        for (int i = 1; i <= 5; i++)
            send_cmd(24'(i), 24'(i));
        check("t5_cmd_ready_full", cmd_ready, 0);
        @(negedge clk);
        cmd_a1 = 24'd6;
        cmd_a2 = 24'd6;
        cmd_valid = 1'b1;
        repeat (40) @(negedge clk);
        check("t5_cmd_ready_held", cmd_ready, 0);
        check("t5_rsp_valid_held", rsp_valid, 1);
        check("t5_rsp_w_held", rsp_w, 32'd1);
        repeat (10) @(negedge clk);
        check("t5_rsp_w_stable", rsp_w, 32'd1);
        cmd_valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            get_rsp(r_w, r_l, r_ovf, r_to);
            check($sformatf("t5_w%0d", i), r_w, exp_w[i]);
            check($sformatf("t5_l%0d", i), r_l, exp_l[i]);
        end
        check("t5_op_count", op_count, 5);
        repeat (40) @(negedge clk);
        check("t5_no_sixth", rsp_valid, 0);

        // Reset during the strobe of a status read
        done_after = 100000;
        send_cmd(24'd9, 24'd9);
        found = 1'b0;
        for (int n = 0; n < 500; n++) begin
            @(negedge clk);
            if (srd && saddress == 16'h03A0) begin
                found = 1'b1;
                break;
            end
        end
        check("t6_stat_strobe_seen", found, 1);
        reset = 1'b1;
        @(negedge clk);
        check("t6_srd", srd, 0);
        check("t6_swr", swr, 0);
        check("t6_rsp_valid", rsp_valid, 0);
        check("t6_busy", busy, 0);
        check("t6_cmd_ready", cmd_ready, 1);
        check("t6_op_count", op_count, 0);
        check("t6_saddress", saddress, 0);
        reset = 1'b0;
        done_after = 1;
        send_cmd(24'd0, 24'd7);
        get_rsp(r_w, r_l, r_ovf, r_to);
        check("t6_w", r_w, 0);
        check("t6_l", r_l, 0);
        check("t6_ovf", r_ovf, 0);
        check("t6_timeout", r_to, 0);
        check("t6_op_count_after", op_count, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mult_seq_master.md
# mult_seq_master

Bus-master sequencer sitting directly upstream of the GPIO-emulated multiply/popcount peripheral. It accepts operand pairs on a valid/ready stream and buffers them in a small FIFO. For each pair it runs the peripheral's register protocol: write A1, write A2, start, poll status, read product W, read ones-count L. It returns one result per command on a valid/ready response stream, so software and testbenches never drive `saddress`/`swr`/`srd` by hand.

## Interface
- `CMD_DEPTH`, 4 — command FIFO entries (power of two, ≥2)
- `STROBE_LEN`, 2 — cycles `swr`/`srd` held high per access (≥1)
- `POLL_LIMIT`, 64 — maximum status reads before timeout (≥1)
- `clk`  in  1  — sole clock; everything on its rising edge
- `reset`  in  1  — synchronous, active-high reset
- `cmd_valid`  in  1  — command offered
- `cmd_ready`  out  1  — FIFO not full
- `cmd_a1`  in  24  — first operand
- `cmd_a2`  in  24  — second operand
- `rsp_valid`  out  1  — result held
- `rsp_ready`  in  1  — result consumed
- `rsp_w`  out  32  — product bits [31:0]
- `rsp_l`  out  6  — ones count of `rsp_w` (0..32)
- `rsp_ovf`  out  1  — product exceeded 32 bits (status bit0 was 0)
- `rsp_timeout`  out  1  — poll limit hit; `rsp_w`/`rsp_l`/`rsp_ovf` forced 0
- `saddress`  out  16  — peripheral register address
- `swr`  out  1  — write strobe
- `srd`  out  1  — read strobe
- `sdata_wr`  out  32  — write data to peripheral `sdata_in`
- `sdata_rd`  in  32  — read data from peripheral `sdata_out`
- `busy`  out  1  — FSM not in IDLE
- `op_count`  out  16  — responses handed off, wraps 0xFFFF→0

## Operation
- Register map: A1=0x0380, A2=0x0388, W=0x0390, L=0x0398, CTRL/STATUS=0x03A0.
- Status word: bit1=done, bit0=valid (1 = no overflow).
- FSM states: IDLE → WR_A1 → WR_A2 → WR_GO → RD_STAT → (done ? RD_W : RD_STAT) → RD_L → RESP → IDLE.
- IDLE: pops the FIFO head when the FIFO is non-empty and no response is pending.
- Write data:
  - WR_A1 / WR_A2 write `{8'h0, operand}`.
  - WR_GO writes 0 to 0x03A0.
- RD_STAT: captures bit0 into `rsp_ovf` as its inverse.
  - If done=0 and the poll count reaches `POLL_LIMIT`, go to RESP with `rsp_timeout`=1.
- RD_W latches `sdata_rd` into `rsp_w`. RD_L latches `sdata_rd[5:0]` into `rsp_l`.
- RESP: `rsp_valid`=1. Stays until `rsp_ready`, then `op_count`+1 and return to IDLE.
- `rsp_*` hold stable while `rsp_valid`=1 and `rsp_ready`=0. No bus activity occurs during RESP.
- FIFO:
  - Push when `cmd_valid && cmd_ready`.
  - A pop in the same cycle as a push on a full FIFO does not raise `cmd_ready` that cycle.
  - Ordering is strict FIFO.
- Reset (any state, including mid-strobe): the next edge forces:
  - `swr`=`srd`=0, `saddress`=0, `sdata_wr`=0
  - `rsp_*`=0, `busy`=0, `op_count`=0
  - FIFO empty; `cmd_ready`=1
- An interrupted peripheral operation is abandoned; the next command fully reprograms it.

## Timing
- Each bus access is `STROBE_LEN`+2 cycles:
  - SETUP: address/data driven, strobes low.
  - STROBE: `STROBE_LEN` cycles, strobe high.
  - HOLD: strobe low, address held; read data sampled at the end of HOLD.
- Address and write data change only in SETUP.
- Push at edge E0 into an empty FIFO with IDLE FSM:
  - Pop at E1.
  - `rsp_valid` rises after edge E1 + (5+k)·(`STROBE_LEN`+2), where k = number of status reads.
  - Defaults with k=1: E25.
- `cmd_ready` is registered: low the cycle after the push that fills the FIFO.
- `busy` rises the cycle after the pop and falls the cycle after the RESP handshake.

## Structure
- Package `mult_seq_pkg`:
  - register address constants
  - status bit indices
  - FSM state enum
  - bus phase enum (SETUP/STROBE/HOLD)
- One sub-module: `sync_fifo`, parameterised width (48) and depth, with full/empty flags.

## Test plan
- Cmd A1=3, A2=5; bus model done after 2 polls:
  - response W=15, L=4, ovf=0, timeout=0
  - address sequence 0x380, 0x388, 0x3A0, 0x3A0, 0x3A0, 0x390, 0x398
- Cmd A1=A2=0xFFFFFF:
  - W=0xFE000001, L=8, ovf=1
- Bus model never sets done:
  - exactly 64 status reads
  - response timeout=1, W=0, L=0, ovf=0
- `rsp_ready` held low; offer 6 commands:
  - 5 accepted, `cmd_ready`=0 after the 5th
  - release `rsp_ready` → 5 responses in order; `op_count`=5
- Assert `reset` during the STROBE of an RD_STAT access:
  - next cycle `srd`=0, `rsp_valid`=0, `busy`=0, `cmd_ready`=1, `op_count`=0
  - fresh cmd A1=0, A2=7 → W=0, L=0
